// File: rtl/joybus_pkg.sv
// Shared JOYBUS definitions: transmitter state encoding, poll commands and bit timing in microseconds.
package joybus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BIT_LO,
    BIT_HI,
    STOP_LO,
    RELEASE,
    WAIT_RSP
  } tx_state_t;

  localparam logic [23:0] CMD_N64_POLL = 24'h010000;
  localparam logic [4:0]  CMD_N64_LEN  = 5'd8;
  localparam logic [23:0] CMD_GC_POLL  = 24'h400300;
  localparam logic [4:0]  CMD_GC_LEN   = 5'd24;

  localparam int unsigned JB_BIT_US   = 4;
  localparam int unsigned JB_SHORT_US = 1;
  localparam int unsigned JB_LONG_US  = 3;

  function automatic logic [15:0] us_cycles(input int unsigned us, input int unsigned clk_per_us);
    return 16'(us * clk_per_us);
  endfunction

endpackage

// File: rtl/joybus_sync.sv
// Two-flop synchroniser for the open-drain JOYBUS line; resets to the idle (high) level.
module joybus_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic ff1;
  logic ff2;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff1 <= 1'b1;
      ff2 <= 1'b1;
    end else begin
      ff1 <= d;
      ff2 <= ff1;
    end
  end

  assign q = ff2;

endmodule

// File: rtl/joybus_tx.sv
// Console-side JOYBUS command transmitter with response-start detection.
// Optional response timeout is built when JOYBUS_TX_TIMEOUT_EN is defined.
module joybus_tx
  import joybus_pkg::*;
#(
  parameter int unsigned CLK_PER_US = 50,
  parameter int unsigned TIMEOUT_US = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [23:0] cmd_data,
  input  logic [4:0]  cmd_len,
  input  logic        JB_RX,
  output logic        jb_tx_oe,
  output logic        tx_busy,
  output logic        rx_start,
  output logic        rsp_timeout
);

  if (CLK_PER_US * JB_LONG_US > 65535) begin : g_bad_clk_per_us
    $error("joybus_tx: CLK_PER_US*3 does not fit the 16-bit phase counter");
  end
  if (TIMEOUT_US * CLK_PER_US > 24'hFFFFFF) begin : g_bad_timeout
    $error("joybus_tx: TIMEOUT_US*CLK_PER_US does not fit the 24-bit timeout counter");
  end

  localparam logic [15:0] T_SHORT = us_cycles(JB_SHORT_US, CLK_PER_US);
  localparam logic [15:0] T_LONG  = us_cycles(JB_LONG_US, CLK_PER_US);

  tx_state_t   state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [23:0] sh, sh_n;
  logic [4:0]  bits, bits_n;
  logic [4:0]  len_c;
  logic        sync, sync_d, fall;
  logic        rx_pulse;
  logic        oe_n;

  joybus_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (JB_RX),
    .q   (sync)
  );

  assign fall  = sync_d & ~sync;
  assign len_c = (cmd_len > 5'd24) ? 5'd24 : cmd_len;

`ifdef JOYBUS_TX_TIMEOUT_EN
  localparam logic [23:0] T_TIMEOUT = 24'(TIMEOUT_US * CLK_PER_US);
  logic [23:0] tcnt;
  logic        to_pulse;

  always_ff @(posedge clk) begin
    if (rst || state != WAIT_RSP) tcnt <= '0;
    else                          tcnt <= tcnt + 24'd1;
  end
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 16'd1;
    sh_n     = sh;
    bits_n   = bits;
    rx_pulse = 1'b0;
`ifdef JOYBUS_TX_TIMEOUT_EN
    to_pulse = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (tx_start) begin
          sh_n    = cmd_data;
          bits_n  = len_c;
          state_n = (len_c == 5'd0) ? STOP_LO : BIT_LO;
        end
      end
      BIT_LO: begin
        if (cnt == (sh[23] ? T_SHORT : T_LONG) - 16'd1) begin
          cnt_n   = '0;
          state_n = BIT_HI;
        end
      end
      BIT_HI: begin
        if (cnt == (sh[23] ? T_LONG : T_SHORT) - 16'd1) begin
          cnt_n   = '0;
          sh_n    = {sh[22:0], 1'b0};
          bits_n  = bits - 5'd1;
          state_n = (bits == 5'd1) ? STOP_LO : BIT_LO;
        end
      end
      STOP_LO: begin
        if (cnt == T_SHORT - 16'd1) begin
          cnt_n   = '0;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        // Our own low drive echoes through the synchroniser; require two clean highs.
        if (!sync) begin
          cnt_n = '0;
        end else if (cnt == 16'd1) begin
          cnt_n   = '0;
          state_n = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        cnt_n = '0;
        if (fall) begin
          rx_pulse = 1'b1;
          state_n  = IDLE;
        end
`ifdef JOYBUS_TX_TIMEOUT_EN
        else if (tcnt == T_TIMEOUT - 24'd1) begin
          to_pulse = 1'b1;
          state_n  = IDLE;
        end
`endif
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
    oe_n = (state_n == BIT_LO) || (state_n == STOP_LO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sh       <= '0;
      bits     <= '0;
      sync_d   <= 1'b1;
      jb_tx_oe <= 1'b0;
      tx_busy  <= 1'b0;
      rx_start <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sh       <= sh_n;
      bits     <= bits_n;
      sync_d   <= sync;
      jb_tx_oe <= oe_n;
      tx_busy  <= (state_n != IDLE);
      rx_start <= rx_pulse;
    end
  end

`ifdef JOYBUS_TX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) rsp_timeout <= 1'b0;
    else     rsp_timeout <= to_pulse;
  end
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_joybus_tx.sv
// Directed bench for joybus_tx: frame waveforms, response detection, busy/zero-length/clamp, reset, timeout.
module tb_joybus_tx;
  import joybus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_start;
  logic [23:0] cmd_data;
  logic [4:0]  cmd_len;
  logic        jb_rx;
  logic        jb_tx_oe;
  logic        tx_busy;
  logic        rx_start;
  logic        rsp_timeout;
  logic        pull;

  int checks   = 0;
  int failures = 0;
  int rx_cnt   = 0;
  int to_cnt   = 0;
  int busy_bad = 0;

  // Open-drain line with pull-up: low if we drive or the modelled controller drives.
  assign jb_rx = !(jb_tx_oe || pull);

  joybus_tx #(.CLK_PER_US(50), .TIMEOUT_US(100)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_start    (tx_start),
    .cmd_data    (cmd_data),
    .cmd_len     (cmd_len),
    .JB_RX       (jb_rx),
    .jb_tx_oe    (jb_tx_oe),
    .tx_busy     (tx_busy),
    .rx_start    (rx_start),
    .rsp_timeout (rsp_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rx_start)    rx_cnt++;
    if (rsp_timeout) to_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tx(input logic [23:0] data, input logic [4:0] len);
    cmd_data = data;
    cmd_len  = len;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
  endtask

  task automatic measure_run(input logic lvl, output int n);
    n = 0;
    while (jb_tx_oe == lvl && n < 6000) begin
      if (!tx_busy) busy_bad++;
      n++;
      tick();
    end
  endtask

  task automatic frame(input string tag, input logic [23:0] data, input int nbits, input int exp_total);
    int n;
    int total;
    logic b;
    total    = 0;
    busy_bad = 0;
    for (int i = 0; i < nbits; i++) begin
      b = data[23-i];
      measure_run(1'b1, n);
      check($sformatf("%s_b%0d_lo", tag, i), n, b ? 50 : 150);
      total += n;
      measure_run(1'b0, n);
      check($sformatf("%s_b%0d_hi", tag, i), n, b ? 150 : 50);
      total += n;
    end
    measure_run(1'b1, n);
    check({tag, "_stop"}, n, 50);
    total += n;
    check({tag, "_total"}, total, exp_total);
    check({tag, "_busy_frame"}, busy_bad, 0);
  endtask

  task automatic respond(input string tag);
    int k;
    int base;
    repeat (150) tick();
    check({tag, "_busy_wait"}, tx_busy, 1);
    base = rx_cnt;
    pull = 1'b1;
    k = 0;
    while (!rx_start && k < 50) begin
      tick();
      k++;
    end
    check({tag, "_rx_lat"}, k, 3);
    check({tag, "_busy_done"}, tx_busy, 0);
    repeat (5) tick();
    pull = 1'b0;
    repeat (5) tick();
    check({tag, "_rx_once"}, rx_cnt - base, 1);
  endtask

  initial begin
    int k;
    int base;
    rst      = 1'b1;
    tx_start = 1'b0;
    cmd_data = '0;
    cmd_len  = '0;
    pull     = 1'b0;
    repeat (3) tick();
    check("rst_oe", jb_tx_oe, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_rx_start", rx_start, 0);
    check("rst_timeout", rsp_timeout, 0);
    rst = 1'b0;
    repeat (3) tick();

    start_tx(CMD_N64_POLL, CMD_N64_LEN);
    frame("n64", CMD_N64_POLL, 8, 1650);
    respond("n64");

    start_tx(CMD_GC_POLL, CMD_GC_LEN);
    frame("gc", CMD_GC_POLL, 24, 4850);
    respond("gc");

    // Second request mid-frame with different data must not disturb the frame.
    start_tx(CMD_N64_POLL, CMD_N64_LEN);
    fork
      begin
        repeat (300) @(posedge clk);
        #2;
        cmd_data = 24'hFFFFFF;
        cmd_len  = 5'd3;
        tx_start = 1'b1;
        @(posedge clk);
        #2;
        tx_start = 1'b0;
      end
    join_none
    frame("busy", CMD_N64_POLL, 8, 1650);
    respond("busy");

    start_tx(24'hFFFFFF, 5'd0);
    frame("zero", 24'hFFFFFF, 0, 50);
    respond("zero");

    start_tx(24'hA5A5A5, 5'd31);
    frame("clamp", 24'hA5A5A5, 24, 4850);
    respond("clamp");

    // Reset sampled at cycle 60 of the first (150-cycle) BIT_LO.
    start_tx(CMD_N64_POLL, CMD_N64_LEN);
    repeat (59) tick();
    check("rstmid_pre_oe", jb_tx_oe, 1);
    rst = 1'b1;
    tick();
    check("rstmid_oe", jb_tx_oe, 0);
    check("rstmid_busy", tx_busy, 0);
    rst  = 1'b0;
    base = rx_cnt;
    repeat (100) tick();
    pull = 1'b1;
    repeat (10) tick();
    pull = 1'b0;
    repeat (20) tick();
    check("rstmid_no_rx", rx_cnt - base, 0);
    check("rstmid_idle_oe", jb_tx_oe, 0);
    check("rstmid_idle_busy", tx_busy, 0);

`ifdef JOYBUS_TX_TIMEOUT_EN
    start_tx(24'h000000, 5'd0);
    frame("to", 24'h000000, 0, 50);
    base = rx_cnt;
    k = 0;
    while (!rsp_timeout && k < 6000) begin
      tick();
      k++;
    end
    check("to_latency", k, 5004);
    check("to_busy", tx_busy, 0);
    repeat (10) tick();
    check("to_once", to_cnt, 1);
    check("to_no_rx", rx_cnt - base, 0);
`else
    check("no_timeout_pulse", to_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
